// File: rtl/enemy_spawn_scheduler.sv
// Walks a level's enemy-queue ROM on play-scene entry and offers each entry
// as a spawn request once the game-time counter reaches its timestamp.
module enemy_spawn_scheduler #(
    parameter int         ADDR_W          = 8,
    parameter int         QUEUE_DEPTH     = 64,
    parameter int         BASE1           = 0,
    parameter int         BASE2           = 64,
    parameter int         BASE3           = 128,
    parameter int         FRAMES_PER_TICK = 6,
    parameter logic [2:0] END_TYPE        = 3'd7
) (
    input  logic              clk_25MHz,
    input  logic              rst,
    input  logic [2:0]        scene,
    input  logic              pause,
    input  logic              frame_tick,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [14:0]       rom_data,
    output logic              spawn_valid,
    output logic [2:0]        spawn_type,
    input  logic              spawn_ready,
    output logic [11:0]       game_time,
    output logic [7:0]        spawn_cnt,
    output logic              queue_done
);
    localparam int IDX_W = $clog2(QUEUE_DEPTH + 1);
    localparam int PRE_W = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FRAMES_PER_TICK - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(QUEUE_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT, LOAD, HOLD, OFFER, DONE} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [IDX_W-1:0]  index_reg, index_next;
    logic [PRE_W-1:0]  pre_reg, pre_next;
    logic [11:0]       gt_reg, gt_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [11:0]       ts_reg, ts_next;
    logic [2:0]        ty_reg, ty_next;
    logic              valid_reg, valid_next;
    logic [2:0]        type_reg, type_next;
    logic              done_reg, done_next;
    logic [2:0]        prev_scene_reg;

    logic              play, prev_play, start, accept;
    logic [ADDR_W-1:0] sel_base;

    assign play      = (scene == 3'd2) || (scene == 3'd3) || (scene == 3'd4);
    assign prev_play = (prev_scene_reg == 3'd2) || (prev_scene_reg == 3'd3) ||
                       (prev_scene_reg == 3'd4);
    assign start     = play && !prev_play;
    assign sel_base  = (scene == 3'd3) ? ADDR_W'(BASE2) :
                       (scene == 3'd4) ? ADDR_W'(BASE3) : ADDR_W'(BASE1);

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        base_next  = base_reg;
        index_next = index_reg;
        pre_next   = pre_reg;
        gt_next    = gt_reg;
        cnt_next   = cnt_reg;
        ts_next    = ts_reg;
        ty_next    = ty_reg;
        valid_next = valid_reg;
        type_next  = type_reg;
        done_next  = done_reg;
        accept     = 1'b0;

        if (state_reg != IDLE && !pause && frame_tick) begin
            if (pre_reg == PRE_LAST) begin
                pre_next = '0;
                if (gt_reg != 12'hFFF) gt_next = gt_reg + 12'd1;
            end else begin
                pre_next = pre_reg + 1'b1;
            end
        end

        case (state_reg)
            WAIT: state_next = LOAD;
            LOAD: begin
                ts_next = rom_data[14:3];
                ty_next = rom_data[2:0];
                if (rom_data[2:0] == END_TYPE) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (gt_reg >= ts_reg && !pause) begin
                    valid_next = 1'b1;
                    type_next  = ty_reg;
                    state_next = OFFER;
                end
            end
            OFFER: begin
                // Ready is only honoured while unpaused; pause drops valid but keeps the entry.
                accept = valid_reg && spawn_ready && !pause;
                if (accept) begin
                    valid_next = 1'b0;
                    if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
                    index_next = index_reg + 1'b1;
                    if (index_next == IDX_END) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        addr_next  = base_reg + ADDR_W'(index_next);
                        state_next = WAIT;
                    end
                end else begin
                    valid_next = !pause;
                end
            end
            DONE: valid_next = 1'b0;
            default: ;
        endcase

        if (!play && state_reg != IDLE) begin
            state_next = IDLE;
            valid_next = 1'b0;
        end

        if (start) begin
            state_next = WAIT;
            gt_next    = '0;
            pre_next   = '0;
            cnt_next   = '0;
            done_next  = 1'b0;
            index_next = '0;
            valid_next = 1'b0;
            base_next  = sel_base;
            addr_next  = sel_base;
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            base_reg       <= '0;
            index_reg      <= '0;
            pre_reg        <= '0;
            gt_reg         <= '0;
            cnt_reg        <= '0;
            ts_reg         <= '0;
            ty_reg         <= '0;
            valid_reg      <= 1'b0;
            type_reg       <= '0;
            done_reg       <= 1'b0;
            prev_scene_reg <= '0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            base_reg       <= base_next;
            index_reg      <= index_next;
            pre_reg        <= pre_next;
            gt_reg         <= gt_next;
            cnt_reg        <= cnt_next;
            ts_reg         <= ts_next;
            ty_reg         <= ty_next;
            valid_reg      <= valid_next;
            type_reg       <= type_next;
            done_reg       <= done_next;
            prev_scene_reg <= scene;
        end
    end

    assign rom_addr    = addr_reg;
    assign spawn_valid = valid_reg;
    assign spawn_type  = type_reg;
    assign game_time   = gt_reg;
    assign spawn_cnt   = cnt_reg;
    assign queue_done  = done_reg;
endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Randomized bench for enemy_spawn_scheduler: a transaction-level model predicts
// spawn order, counts, issue timing and game time from the ROM contents and ticks.
module tb_enemy_spawn_scheduler;
    logic        clk_25MHz = 1'b0;
    logic        rst;
    logic [2:0]  scene;
    logic        pause;
    logic        frame_tick;
    logic [7:0]  rom_addr;
    logic [14:0] rom_data;
    logic        spawn_valid;
    logic [2:0]  spawn_type;
    logic        spawn_ready;
    logic [11:0] game_time;
    logic [7:0]  spawn_cnt;
    logic        queue_done;

    enemy_spawn_scheduler dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .scene(scene), .pause(pause),
        .frame_tick(frame_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .spawn_valid(spawn_valid), .spawn_type(spawn_type), .spawn_ready(spawn_ready),
        .game_time(game_time), .spawn_cnt(spawn_cnt), .queue_done(queue_done)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    logic [14:0] rom [0:255];
    always @(posedge clk_25MHz) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_mode = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit is_play(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic int base_of(input logic [2:0] s);
        return (s == 3'd3) ? 64 : (s == 3'd4) ? 128 : 0;
    endfunction

    function automatic int gt_of(input int t);
        return (t / 6 > 4095) ? 4095 : t / 6;
    endfunction

    always @(posedge clk_25MHz) cyc <= cyc + 1;

    // Game-time model: frame ticks counted while a game is running and unpaused.
    int       ticks;
    bit       m_active;
    logic [2:0] m_prev;
    always @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            ticks    <= 0;
            m_active <= 1'b0;
            m_prev   <= 3'd0;
        end else begin
            if (is_play(scene) && !is_play(m_prev)) begin
                ticks    <= 0;
                m_active <= 1'b1;
            end else begin
                if (m_active && frame_tick && !pause) ticks <= ticks + 1;
                if (!is_play(scene)) m_active <= 1'b0;
            end
            m_prev <= scene;
        end
    end

    initial begin
        frame_tick = 1'b0;
        forever begin
            @(posedge clk_25MHz);
            #1;
            case (tick_mode)
                0:       frame_tick = 1'b0;
                1:       frame_tick = 1'b1;
                default: frame_tick = 1'($urandom % 2);
            endcase
        end
    end

    // Transaction monitor/scoreboard.
    int   exp_ty[$];
    int   exp_ts[$];
    bit   mon_active, prev_valid, cnt_pending, first_pending, pause_seen, ended;
    logic [2:0] prev_scene_s;
    int   mcnt, last_evt, due, done_at, last_gt, max_addr;

    initial begin
        int g, t, d, e;
        mon_active = 0; prev_valid = 0; cnt_pending = 0; first_pending = 0;
        pause_seen = 0; ended = 0; prev_scene_s = 3'd0; mcnt = 0; last_evt = 0;
        due = -1; done_at = -1; last_gt = 0; max_addr = 0;
        forever begin
            @(negedge clk_25MHz);
            if (!rst) begin
                exp_ty.delete(); exp_ts.delete();
                mon_active = 0; prev_valid = 0; cnt_pending = 0; done_at = -1;
                prev_scene_s = 3'd0; last_gt = 0; mcnt = 0;
            end else begin
                g = gt_of(ticks);
                if (g != last_gt) begin
                    check("game_time", game_time, g);
                    last_gt = g;
                end
                if (cnt_pending) begin
                    check("spawn_cnt", spawn_cnt, mcnt);
                    cnt_pending = 0;
                end
                if (done_at == cyc) begin
                    check("done_time", queue_done, 1);
                    done_at = -1;
                end
                if (is_play(scene) && !is_play(prev_scene_s)) begin
                    exp_ty.delete(); exp_ts.delete();
                    ended = 0;
                    for (int i = 0; i < 64 && !ended; i++) begin
                        e = base_of(scene) + i;
                        if (rom[e][2:0] == 3'd7) ended = 1;
                        else begin
                            exp_ty.push_back(int'(rom[e][2:0]));
                            exp_ts.push_back(int'(rom[e][14:3]));
                        end
                    end
                    mon_active = 1; mcnt = 0; last_evt = cyc + 1; due = -1;
                    first_pending = 1; pause_seen = 0; done_at = -1;
                    max_addr = base_of(scene);
                end else if (!is_play(scene)) begin
                    mon_active = 0;
                end else if (mon_active) begin
                    if (exp_ts.size() > 0 && due < 0 && g >= exp_ts[0]) due = cyc;
                    if (pause) pause_seen = 1;
                    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
                    if (spawn_valid && !prev_valid && first_pending) begin
                        first_pending = 0;
                        check("queue_nonempty_at_rise", int'(exp_ts.size() > 0), 1);
                        if (exp_ts.size() > 0 && !pause_seen)
                            check("rise_cycle", cyc, (last_evt + 3 > due + 1) ? last_evt + 3 : due + 1);
                    end
                    if (spawn_valid && spawn_ready && !pause) begin
                        check("queue_nonempty_at_accept", int'(exp_ty.size() > 0), 1);
                        if (exp_ty.size() > 0) begin
                            t = exp_ty.pop_front();
                            d = exp_ts.pop_front();
                            check("spawn_type", spawn_type, t);
                            mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                            cnt_pending = 1; last_evt = cyc + 1; due = -1;
                            first_pending = 1; pause_seen = 0;
                            $display("spawn %0d: type %0d ts %0d accepted at cycle %0d", mcnt, t, d, cyc + 1);
                            if (exp_ty.size() == 0) done_at = ended ? cyc + 3 : cyc + 1;
                        end
                    end
                end
                prev_valid   = spawn_valid;
                prev_scene_s = scene;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_25MHz);
            #1;
        end
    endtask

    task automatic enter(input logic [2:0] from_s, input logic [2:0] to_s);
        scene = from_s;
        step(2);
        scene = to_s;
        step(1);
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int n = 0;
        while (!spawn_valid && n < bound) begin
            step(1);
            n++;
        end
        check(tag, spawn_valid, 1);
    endtask

    task automatic wait_done(input int bound, input string tag);
        int n = 0;
        while (!queue_done && n < bound) begin
            step(1);
            n++;
        end
        check(tag, queue_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0, bad, n, ts;
        rst = 1'b0; scene = 3'd0; pause = 1'b0; spawn_ready = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = {12'd0, 3'd7};

        // Reset state
        step(3);
        check("rst_addr", rom_addr, 0);
        check("rst_valid", spawn_valid, 0);
        check("rst_type", spawn_type, 0);
        check("rst_gt", game_time, 0);
        check("rst_cnt", spawn_cnt, 0);
        check("rst_done", queue_done, 0);
        rst = 1'b1;
        step(2);

        // Single timed spawn, level 1
        rom[0] = {12'd2, 3'd1};
        rom[1] = {12'd0, 3'd7};
        tick_mode = 1; spawn_ready = 1'b1;
        enter(3'd1, 3'd2);
        wait_done(200, "t1_done");
        check("t1_cnt", spawn_cnt, 1);
        check("t1_gt", game_time, gt_of(ticks));

        // Back-pressure on level 3, then back-to-back issue
        tick_mode = 0; spawn_ready = 1'b0;
        rom[128] = {12'd0, 3'd2};
        rom[129] = {12'd0, 3'd3};
        rom[130] = {12'd0, 3'd4};
        rom[131] = {12'd0, 3'd7};
        enter(3'd0, 3'd4);
        step(50);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!spawn_valid || spawn_type != 3'd2) bad++;
            step(1);
        end
        check("t2_hold_stable", bad, 0);
        check("t2_type", spawn_type, 2);
        spawn_ready = 1'b1;
        wait_done(100, "t2_done");
        check("t2_cnt", spawn_cnt, 3);

        // Pause during OFFER
        spawn_ready = 1'b0; tick_mode = 1;
        rom[0] = {12'd0, 3'd5};
        rom[1] = {12'd0, 3'd7};
        enter(3'd0, 3'd2);
        wait_valid(50, "t3_valid");
        pause = 1'b1;
        step(1);
        check("t3_pause_valid", spawn_valid, 0);
        g0 = game_time;
        step(12);
        check("t3_gt_frozen", game_time, g0);
        check("t3_still_low", spawn_valid, 0);
        pause = 1'b0;
        step(1);
        check("t3_resume_valid", spawn_valid, 1);
        check("t3_resume_type", spawn_type, 5);
        spawn_ready = 1'b1;
        wait_done(50, "t3_done");

        // Full 64-entry level 2, random ready/pause/ticks
        ts = 0;
        for (int i = 0; i < 64; i++) begin
            ts += $urandom % 3;
            rom[64 + i] = {12'(ts), 3'($urandom % 7)};
        end
        tick_mode = 2; spawn_ready = 1'b0;
        enter(3'd0, 3'd3);
        n = 0;
        while (!queue_done && n < 20000) begin
            spawn_ready = 1'($urandom % 2);
            pause = ($urandom % 8) == 0;
            step(1);
            n++;
        end
        pause = 1'b0; spawn_ready = 1'b0;
        check("t4_done", queue_done, 1);
        check("t4_cnt", spawn_cnt, 64);
        check("t4_addr_max", max_addr, 127);
        step(5);
        check("t4_addr_hold", rom_addr, 127);

        // Leave mid-OFFER, then re-enter
        tick_mode = 1;
        rom[0] = {12'd0, 3'd3};
        rom[1] = {12'd0, 3'd4};
        rom[2] = {12'd0, 3'd7};
        spawn_ready = 1'b1;
        enter(3'd0, 3'd2);
        n = 0;
        while (spawn_cnt != 8'd1 && n < 50) begin
            step(1);
            n++;
        end
        spawn_ready = 1'b0;
        check("t5_first_cnt", spawn_cnt, 1);
        wait_valid(50, "t5_valid");
        scene = 3'd5;
        step(1);
        check("t5_leave_valid", spawn_valid, 0);
        g0 = game_time;
        step(20);
        check("t5_gt_held", game_time, g0);
        check("t5_cnt_held", spawn_cnt, 1);
        check("t5_no_valid", spawn_valid, 0);
        scene = 3'd2;
        step(1);
        check("t5_gt_zero", game_time, 0);
        check("t5_cnt_zero", spawn_cnt, 0);
        check("t5_addr_base", rom_addr, 0);
        spawn_ready = 1'b1;
        wait_done(100, "t5_done");
        check("t5_cnt_final", spawn_cnt, 2);

        // Asynchronous reset mid-WAIT
        spawn_ready = 1'b0;
        enter(3'd0, 3'd3);
        check("t6_addr_pre", rom_addr, 64);
        rst = 1'b0;
        #2;
        check("t6_addr", rom_addr, 0);
        check("t6_valid", spawn_valid, 0);
        check("t6_type", spawn_type, 0);
        check("t6_gt", game_time, 0);
        check("t6_cnt", spawn_cnt, 0);
        check("t6_done", queue_done, 0);
        scene = 3'd0;
        step(3);
        rst = 1'b1;
        step(20);
        check("t6_gt_idle", game_time, 0);
        check("t6_valid_idle", spawn_valid, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
